freq_gate_controller: RTL and testbench

- Sequences one frequency-measurement cycle for the display front end.
- On `start` it clears the edge counter, opens a gate window of exactly GATE_CYCLES clocks, and counts rising edges of the asynchronous `sig_in` during that window.
- It then latches the count and presents it to the display with a valid/ack handshake.
- It replaces ad-hoc gate flip-flop and gate timer logic with one synchronous state machine, clocked by clk only.

---
 rtl/freq_meas_pkg.sv | 16 +
 rtl/freq_gate_controller_edge_sync.sv | 28 ++
 rtl/freq_gate_controller.sv | 122 ++++++++++++
 tb/tb_freq_gate_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_meas_pkg.sv
// Shared definitions for the frequency-measurement front end:
// the sequencer state encoding and the default sizing constants.
package freq_meas_pkg;

    localparam int DEF_GATE_CYCLES = 500;
    localparam int SYNC_STAGES     = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        GATE  = 3'd2,
        LATCH = 3'd3,
        HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/freq_gate_controller_edge_sync.sv
// Brings an asynchronous level into the clk domain and emits a one-cycle
// pulse on each synchronized rising edge.
module edge_sync
    import freq_meas_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse_out
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchronizer chain, previous-value flop and registered edge pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r    <= {SYNC_STAGES{1'b0}};
            prev_r    <= 1'b0;
            pulse_out <= 1'b0;
        end else begin
            sync_r    <= {sync_r[SYNC_STAGES-2:0], async_in};
            prev_r    <= sync_r[SYNC_STAGES-1];
            pulse_out <= sync_r[SYNC_STAGES-1] & ~prev_r;
        end
    end

endmodule

// File: rtl/freq_gate_controller.sv
// Single-clock sequencer for one frequency measurement: arm, count sig_in
// rising edges over a fixed gate window, latch, then hand off via valid/ack.
module freq_gate_controller
    import freq_meas_pkg::*;
#(
    parameter int GATE_CYCLES  = DEF_GATE_CYCLES,
    parameter int CNT_W        = 8,
    parameter int AUTO_RESTART = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sig_in,
    input  logic             result_ack,
    output logic             gate,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             overflow
);

    localparam int               TMR_W    = $clog2(GATE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_t             state_r;
    state_t             next_s;
    logic [TMR_W-1:0]   timer_r;
    logic [CNT_W-1:0]   count_r;
    logic               sat_r;
    logic               pulse_s;

    edge_sync u_edge_sync (
        .clk       (clk),
        .reset     (reset),
        .async_in  (sig_in),
        .pulse_out (pulse_s)
    );

    // Next-state decode; start and result_ack only matter in IDLE and HOLD
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_s = ARM;
                else       next_s = IDLE;
            end
            ARM:   next_s = GATE;
            GATE: begin
                if (timer_r == TMR_ZERO) next_s = LATCH;
                else                     next_s = GATE;
            end
            LATCH: next_s = HOLD;
            HOLD: begin
                if (result_ack) next_s = (AUTO_RESTART != 0) ? ARM : IDLE;
                else            next_s = HOLD;
            end
            default: next_s = IDLE;
        endcase
    end

    // State register with gate/busy registered from the next state so they
    // line up exactly with the state they describe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            gate    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_r <= next_s;
            gate    <= (next_s == GATE);
            busy    <= (next_s != IDLE);
        end
    end

    // Gate timer and saturating edge counter; pulses outside GATE are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_r <= TMR_ZERO;
            count_r <= CNT_ZERO;
            sat_r   <= 1'b0;
        end else begin
            case (state_r)
                ARM: begin
                    timer_r <= TMR_LOAD;
                    count_r <= CNT_ZERO;
                    sat_r   <= 1'b0;
                end
                GATE: begin
                    if (timer_r != TMR_ZERO) timer_r <= timer_r - 1'b1;
                    if (pulse_s) begin
                        if (count_r == CNT_MAX) sat_r   <= 1'b1;
                        else                    count_r <= count_r + 1'b1;
                    end
                end
                default: begin
                    timer_r <= timer_r;
                end
            endcase
        end
    end

    // Result hand-off: latched once per window, held until the next latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result       <= CNT_ZERO;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            if (state_r == LATCH) begin
                result       <= count_r;
                overflow     <= sat_r;
                result_valid <= 1'b1;
            end else if ((state_r == HOLD) && result_ack) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_freq_gate_controller.sv
// Self-checking bench: two controller instances (plain and auto-restart with a
// narrow counter) checked against an edge-history reference model.
module tb_freq_gate_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       sig_in;
    logic       start1, start2, ack1, ack2;
    logic       gate1, busy1, valid1, ovf1;
    logic       gate2, busy2, valid2, ovf2;
    logic [7:0] res1;
    logic [5:0] res2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int cur    = 0;
    int last_res = 0;

    int sig_mode = 0;
    int sig_per  = 10;
    int sig_base = 0;
    bit hist [0:16383];

    logic       o_gate, o_busy, o_valid, o_ovf;
    logic [7:0] o_res;

    freq_gate_controller #(.GATE_CYCLES(500), .CNT_W(8), .AUTO_RESTART(0)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .sig_in(sig_in), .result_ack(ack1),
        .gate(gate1), .busy(busy1), .result(res1), .result_valid(valid1), .overflow(ovf1)
    );

    freq_gate_controller #(.GATE_CYCLES(300), .CNT_W(6), .AUTO_RESTART(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .sig_in(sig_in), .result_ack(ack2),
        .gate(gate2), .busy(busy2), .result(res2), .result_valid(valid2), .overflow(ovf2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus source: the value driven here is what the next posedge captures
    always @(negedge clk) begin
        logic v;
        int   n;
        n = cyc + 1;
        case (sig_mode)
            1:       v = (n >= sig_base) && (((n - sig_base) % sig_per) < (sig_per / 2));
            2:       v = 1'($urandom_range(0, 1));
            default: v = 1'b0;
        endcase
        sig_in = v;
        if (n < 16384) hist[n] = v;
    end

    always_comb begin
        if (cur == 0) begin
            o_gate = gate1; o_busy = busy1; o_valid = valid1; o_ovf = ovf1; o_res = res1;
        end else begin
            o_gate = gate2; o_busy = busy2; o_valid = valid2; o_ovf = ovf2; o_res = {2'b00, res2};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive_start(input logic v);
        if (cur == 0) start1 = v; else start2 = v;
    endtask

    task automatic drive_ack(input logic v);
        if (cur == 0) ack1 = v; else ack2 = v;
    endtask

    // Reference: a rise first captured at posedge a is counted when a lies in
    // [s-1, s+gc-2], s being the posedge that sampled start (two sync flops
    // plus the pulse register put the count three edges after capture).
    function automatic int model_count(input int s, input int gc);
        int n = 0;
        for (int a = s - 1; a <= s + gc - 2; a++)
            if (hist[a] && !hist[a-1]) n++;
        return n;
    endfunction

    // Entered at the negedge just after the arming posedge s
    task automatic run_window(input int gc, input int cw, input int start_at, input string tag);
        int s;
        int gates;
        int n;
        int mx;
        s = cyc;
        gates = 0;
        chk({tag, ".arm_busy"}, o_busy, 1);
        chk({tag, ".arm_gate"}, o_gate, 0);
        for (int g = 1; g <= gc; g++) begin
            @(negedge clk);
            drive_start((g == start_at) ? 1'b1 : 1'b0);
            gates += int'(o_gate);
        end
        drive_start(1'b0);
        chk({tag, ".gate_len"}, gates, gc);
        @(negedge clk);
        chk({tag, ".latch_gate"}, o_gate, 0);
        chk({tag, ".latch_busy"}, o_busy, 1);
        chk({tag, ".latch_valid"}, o_valid, 0);
        @(negedge clk);
        n  = model_count(s, gc);
        mx = (1 << cw) - 1;
        last_res = (n > mx) ? mx : n;
        chk({tag, ".valid"}, o_valid, 1);
        chk({tag, ".result"}, o_res, last_res);
        chk({tag, ".overflow"}, o_ovf, (n > mx) ? 1 : 0);
    endtask

    task automatic kick(input int gc, input int cw, input int start_at, input string tag);
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        run_window(gc, cw, start_at, tag);
    endtask

    task automatic do_ack(input bit autore, input string tag);
        @(negedge clk);
        drive_ack(1'b1);
        @(negedge clk);
        drive_ack(1'b0);
        chk({tag, ".ack_valid"}, o_valid, 0);
        chk({tag, ".ack_busy"}, o_busy, autore ? 1 : 0);
        chk({tag, ".ack_result"}, o_res, last_res);
    endtask

    initial begin
        reset = 1'b1;
        start1 = 1'b0; start2 = 1'b0; ack1 = 1'b0; ack2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.gate", gate1, 0);
        chk("rst.busy", busy1, 0);
        chk("rst.valid", valid1, 0);
        chk("rst.result", res1, 0);
        chk("rst.overflow", ovf1, 0);
        chk("rst.busy2", busy2, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Basic count: period 10, first rise 20 clocks after start
        @(negedge clk);
        sig_mode = 1; sig_per = 10; sig_base = cyc + 21;
        kick(500, 8, 0, "basic");

        // Handshake: no ack for 100 cycles
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("hold.valid", o_valid, 1);
            chk("hold.busy", o_busy, 1);
            chk("hold.result", o_res, last_res);
        end
        do_ack(1'b0, "basic");

        // Start pulsed during the gate is ignored and not queued
        sig_mode = 2;
        @(negedge clk);
        kick(500, 8, 200, "busy_start");
        do_ack(1'b0, "busy_start");
        repeat (5) @(negedge clk);
        chk("busy_start.idle", o_busy, 0);

        // Reset mid-gate clears everything at once
        @(negedge clk);
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        repeat (250) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst.gate", gate1, 0);
        chk("midrst.busy", busy1, 0);
        chk("midrst.valid", valid1, 0);
        chk("midrst.result", res1, 0);
        chk("midrst.overflow", ovf1, 0);
        @(negedge clk);
        reset = 1'b0;
        sig_mode = 1; sig_per = 6; sig_base = cyc + 3;
        repeat (10) @(negedge clk);
        kick(500, 8, 0, "post_reset");
        do_ack(1'b0, "post_reset");

        // Randomized patterns
        for (int r = 0; r < 3; r++) begin
            if (r == 1) sig_mode = 2;
            else begin
                sig_mode = 1;
                sig_per  = int'($urandom_range(2, 12));
                sig_base = cyc + int'($urandom_range(0, 30));
            end
            @(negedge clk);
            kick(500, 8, 0, "random");
            do_ack(1'b0, "random");
        end

        // Narrow counter saturates, then auto-restart with no edges
        cur = 1;
        sig_mode = 1; sig_per = 4; sig_base = cyc + 2;
        @(negedge clk);
        kick(300, 6, 0, "ovf");
        sig_mode = 0;
        repeat (4) @(negedge clk);
        do_ack(1'b1, "ovf");
        run_window(300, 6, 0, "auto_zero");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
